// File: rtl/gate_response_checker_pkg.sv
// Shared gate op codes and checker FSM state encodings.
// Reused by the checker, the reference model and stimulus benches.
package gate_response_checker_pkg;

  localparam logic [2:0] OP_NOT  = 3'd0;
  localparam logic [2:0] OP_BUF  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_XNOR = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/gate_response_checker_gate_ref_model.sv
// gate_ref_model: combinational golden model of the selected gate.
// Ports: op (gate select), a, b (operands), y_exp (expected output).
module gate_ref_model
  import gate_response_checker_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y_exp
);

  always_comb begin
    y_exp = '0;
    case (op)
      OP_NOT:  y_exp = ~a;
      OP_BUF:  y_exp = a;
      OP_AND:  y_exp = a & b;
      OP_OR:   y_exp = a | b;
      OP_NAND: y_exp = ~(a & b);
      OP_NOR:  y_exp = ~(a | b);
      OP_XOR:  y_exp = a ^ b;
      OP_XNOR: y_exp = ~(a ^ b);
      default: y_exp = '0;
    endcase
  end

endmodule

// File: rtl/gate_response_checker.sv
// gate_response_checker: compares GUT output against a gate model,
// counts vectors/errors, captures the first failing index.
// Ports: clk, rst (async high), start/stop session pulses, op select,
// s_valid/s_a/s_b/s_y vector in; busy, done, pass, mismatch,
// vec_cnt, err_cnt, first_err_valid, first_err_idx out.
module gate_response_checker
  import gate_response_checker_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [2:0]       op,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_a,
  input  logic [WIDTH-1:0] s_b,
  input  logic [WIDTH-1:0] s_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_idx
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [1:0]       state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] y_exp;
  logic             fail;

  gate_ref_model #(
    .WIDTH(WIDTH)
  ) u_ref (
    .op   (op_q),
    .a    (s_a),
    .b    (s_b),
    .y_exp(y_exp)
  );

  assign fail = (y_exp != s_y);
  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign pass = done && (vec_cnt != '0) && (err_cnt == '0);

  // start takes priority over any vector or stop in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      op_q            <= 3'd0;
      mismatch        <= 1'b0;
      vec_cnt         <= '0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
    end else begin
      mismatch <= 1'b0;
      if (start) begin
        state_q         <= ST_RUN;
        op_q            <= op;
        vec_cnt         <= '0;
        err_cnt         <= '0;
        first_err_valid <= 1'b0;
        first_err_idx   <= '0;
      end else if (state_q == ST_RUN) begin
        if (s_valid) begin
          if (vec_cnt != CNT_MAX)
            vec_cnt <= vec_cnt + CNT_ONE;
          if (fail) begin
            mismatch <= 1'b1;
            if (err_cnt != CNT_MAX)
              err_cnt <= err_cnt + CNT_ONE;
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_idx   <= vec_cnt;
            end
          end
        end
        if (stop)
          state_q <= ST_DONE;
      end
    end
  end

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker: a WIDTH=1/CNT_W=16
// instance (n_*) and a WIDTH=4/CNT_W=3 instance (w_*).
module tb_gate_response_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        n_start = 0, n_stop = 0, n_valid = 0;
  logic [2:0]  n_op = 0;
  logic        n_a = 0, n_b = 0, n_y = 0;
  logic        n_busy, n_done, n_pass, n_mm, n_fev;
  logic [15:0] n_vec, n_err, n_idx;

  logic        w_start = 0, w_stop = 0, w_valid = 0;
  logic [2:0]  w_op = 0;
  logic [3:0]  w_a = 0, w_b = 0, w_y = 0;
  logic        w_busy, w_done, w_pass, w_mm, w_fev;
  logic [2:0]  w_vec, w_err, w_idx;

  int n_checks = 0;
  int n_fails  = 0;

  gate_response_checker #(.WIDTH(1), .CNT_W(16)) u_n (
    .clk(clk), .rst(rst), .start(n_start), .stop(n_stop),
    .op(n_op), .s_valid(n_valid), .s_a(n_a), .s_b(n_b),
    .s_y(n_y), .busy(n_busy), .done(n_done), .pass(n_pass),
    .mismatch(n_mm), .vec_cnt(n_vec), .err_cnt(n_err),
    .first_err_valid(n_fev), .first_err_idx(n_idx)
  );

  gate_response_checker #(.WIDTH(4), .CNT_W(3)) u_w (
    .clk(clk), .rst(rst), .start(w_start), .stop(w_stop),
    .op(w_op), .s_valid(w_valid), .s_a(w_a), .s_b(w_b),
    .s_y(w_y), .busy(w_busy), .done(w_done), .pass(w_pass),
    .mismatch(w_mm), .vec_cnt(w_vec), .err_cnt(w_err),
    .first_err_valid(w_fev), .first_err_idx(w_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic n_begin(input logic [2:0] op);
    n_op = op;
    n_start = 1;
    step();
    n_start = 0;
  endtask

  task automatic n_end();
    n_stop = 1;
    step();
    n_stop = 0;
  endtask

  task automatic nv(input logic a, input logic b, input logic y);
    n_valid = 1;
    n_a = a;
    n_b = b;
    n_y = y;
    step();
    n_valid = 0;
  endtask

  task automatic wv(input logic [3:0] a, input logic [3:0] b,
                    input logic [3:0] y);
    w_valid = 1;
    w_a = a;
    w_b = b;
    w_y = y;
    step();
    w_valid = 0;
  endtask

  initial begin
    #3 rst = 1;
    #1;
    check("rst_busy", 32'(n_busy), 0);
    check("rst_done", 32'(n_done), 0);
    check("rst_pass", 32'(n_pass), 0);
    check("rst_mm", 32'(n_mm), 0);
    check("rst_vec", 32'(n_vec), 0);
    check("rst_err", 32'(n_err), 0);
    check("rst_fev", 32'(n_fev), 0);
    check("rst_idx", 32'(n_idx), 0);
    step();
    rst = 0;
    step();

    // vector while IDLE is ignored
    nv(0, 0, 1);
    nv(0, 0, 0);
    check("idle_vec", 32'(n_vec), 0);
    check("idle_err", 32'(n_err), 0);
    check("idle_mm", 32'(n_mm), 0);
    check("idle_busy", 32'(n_busy), 0);

    // NOT, all good
    n_begin(3'd0);
    check("t1_busy", 32'(n_busy), 1);
    nv(0, 0, 1);
    check("t1_mm0", 32'(n_mm), 0);
    nv(1, 0, 0);
    check("t1_mm1", 32'(n_mm), 0);
    nv(0, 0, 1);
    check("t1_mm2", 32'(n_mm), 0);
    n_end();
    check("t1_vec", 32'(n_vec), 3);
    check("t1_err", 32'(n_err), 0);
    check("t1_fev", 32'(n_fev), 0);
    check("t1_done", 32'(n_done), 1);
    check("t1_pass", 32'(n_pass), 1);
    check("t1_busy", 32'(n_busy), 0);
    check("t1_mm", 32'(n_mm), 0);

    // NOT with two failures; op change mid-run has no effect
    n_begin(3'd0);
    n_op = 3'd1;
    check("t2_clr_vec", 32'(n_vec), 0);
    check("t2_clr_done", 32'(n_done), 0);
    nv(0, 0, 1);
    check("t2_mm0", 32'(n_mm), 0);
    nv(1, 0, 1);
    check("t2_mm1", 32'(n_mm), 1);
    check("t2_fev1", 32'(n_fev), 1);
    check("t2_idx1", 32'(n_idx), 1);
    nv(0, 0, 0);
    check("t2_mm2", 32'(n_mm), 1);
    nv(1, 0, 0);
    check("t2_mm3", 32'(n_mm), 0);
    step();
    check("t2_mm4", 32'(n_mm), 0);
    n_end();
    check("t2_vec", 32'(n_vec), 4);
    check("t2_err", 32'(n_err), 2);
    check("t2_idx", 32'(n_idx), 1);
    check("t2_fev", 32'(n_fev), 1);
    check("t2_done", 32'(n_done), 1);
    check("t2_pass", 32'(n_pass), 0);

    // stop in DONE ignored, valid in DONE ignored
    nv(1, 0, 1);
    n_end();
    check("done_vec", 32'(n_vec), 4);
    check("done_hold", 32'(n_done), 1);

    // AND: s_valid together with stop
    n_begin(3'd2);
    n_stop = 1;
    nv(1, 1, 1);
    n_stop = 0;
    check("vs_vec", 32'(n_vec), 1);
    check("vs_done", 32'(n_done), 1);
    check("vs_pass", 32'(n_pass), 1);

    // OR: s_valid together with start in RUN
    n_begin(3'd3);
    nv(1, 0, 0);
    check("st_err_pre", 32'(n_err), 1);
    n_start = 1;
    nv(1, 0, 0);
    n_start = 0;
    check("st_vec", 32'(n_vec), 0);
    check("st_err", 32'(n_err), 0);
    check("st_fev", 32'(n_fev), 0);
    check("st_mm", 32'(n_mm), 0);
    check("st_busy", 32'(n_busy), 1);

    // empty session
    n_begin(3'd3);
    n_end();
    check("empty_done", 32'(n_done), 1);
    check("empty_pass", 32'(n_pass), 0);

    // async reset mid-run after two errors
    n_begin(3'd0);
    nv(0, 0, 0);
    nv(1, 0, 1);
    check("ar_err_pre", 32'(n_err), 2);
    #2 rst = 1;
    #1;
    check("ar_err", 32'(n_err), 0);
    check("ar_vec", 32'(n_vec), 0);
    check("ar_fev", 32'(n_fev), 0);
    check("ar_busy", 32'(n_busy), 0);
    check("ar_mm", 32'(n_mm), 0);
    step();
    rst = 0;
    n_begin(3'd4);
    nv(1, 1, 0);
    n_end();
    check("ar2_vec", 32'(n_vec), 1);
    check("ar2_err", 32'(n_err), 0);
    check("ar2_pass", 32'(n_pass), 1);

    // WIDTH=4 XOR
    w_op = 3'd6;
    w_start = 1;
    step();
    w_start = 0;
    wv(4'hA, 4'h5, 4'hF);
    check("x_mm0", 32'(w_mm), 0);
    wv(4'hA, 4'hA, 4'h1);
    check("x_mm1", 32'(w_mm), 1);
    w_stop = 1;
    step();
    w_stop = 0;
    check("x_vec", 32'(w_vec), 2);
    check("x_err", 32'(w_err), 1);
    check("x_idx", 32'(w_idx), 1);
    check("x_pass", 32'(w_pass), 0);

    // CNT_W=3 saturation with XNOR, all vectors fail
    w_op = 3'd7;
    w_start = 1;
    step();
    w_start = 0;
    for (int i = 0; i < 10; i++)
      wv(4'h0, 4'h0, 4'h0);
    check("sat_mm", 32'(w_mm), 1);
    check("sat_vec", 32'(w_vec), 7);
    check("sat_err", 32'(w_err), 7);
    check("sat_idx", 32'(w_idx), 0);
    check("sat_fev", 32'(w_fev), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
